// File: rtl/mux_guard.sv
// mux_guard: break-before-make guard for NCH analog-mux address fields with sticky collision fault.
// Define MUX_GUARD_CNT_EN to build the saturating fault-entry counter; otherwise conflict_cnt is tied to 0.
module mux_guard #(
  parameter int NCH    = 3,
  parameter int ADR_W  = 4,
  parameter int SETTLE = 4,
  parameter int CNT_W  = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NCH*ADR_W-1:0] adr_in,
  input  logic                 mux_en_in,
  input  logic                 fault_clr,
  output logic [NCH*ADR_W-1:0] adr_out,
  output logic                 mux_en_out,
  output logic [NCH-1:0]       conflict_mask,
  output logic                 fault,
  output logic [CNT_W-1:0]     conflict_cnt
);
  localparam int TW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [TW-1:0] TLAST = TW'(SETTLE - 1);
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_EN, ST_FAULT} state_t;
  state_t               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [NCH*ADR_W-1:0] adr_q, adr_d;
  logic [NCH-1:0]       mask_q, mask_d;
  logic                 mux_en_q, mux_en_d, fault_q, fault_d;
  logic                 conflict, stable;
  always_comb begin
    mask_d = '0;
    for (int i = 0; i < NCH; i++)
      for (int j = 0; j < NCH; j++)
        if (i != j && adr_q[i*ADR_W +: ADR_W] == adr_q[j*ADR_W +: ADR_W]) mask_d[i] = 1'b1;
  end
  assign conflict = |mask_d;
  assign stable   = (adr_in == adr_q);
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE:
        if (mux_en_in && conflict) state_d = ST_FAULT;
        else if (mux_en_in && stable) begin
          state_d = ST_SETTLE;
          timer_d = '0;
        end
      ST_SETTLE:
        if (conflict) state_d = ST_FAULT;
        else if (!mux_en_in || !stable) state_d = ST_IDLE;
        else if (timer_q == TLAST) state_d = ST_EN;
        else timer_d = timer_q + 1'b1;
      ST_EN:
        if (!mux_en_in || !stable) state_d = ST_IDLE;
      default:
        if (fault_clr) state_d = ST_IDLE;
    endcase
    // Addresses freeze only while the mux stays enabled; leaving ENABLED picks up the new address at once.
    adr_d    = (state_d == ST_EN) ? adr_q : adr_in;
    mux_en_d = (state_d == ST_EN);
    fault_d  = (state_d == ST_FAULT);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      adr_q    <= '0;
      mask_q   <= '0;
      mux_en_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      adr_q    <= adr_d;
      mask_q   <= mask_d;
      mux_en_q <= mux_en_d;
      fault_q  <= fault_d;
    end
  end
`ifdef MUX_GUARD_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = (state_d == ST_FAULT && state_q != ST_FAULT && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign conflict_cnt = cnt_q;
`else
  assign conflict_cnt = '0;
`endif
  assign adr_out       = adr_q;
  assign mux_en_out    = mux_en_q;
  assign conflict_mask = mask_q;
  assign fault         = fault_q;
endmodule

// File: tb/tb_mux_guard.sv
// tb_mux_guard: directed stimulus with a rule-level reference model checked every cycle, plus literal checkpoints.
module tb_mux_guard;
  localparam int NCH = 3, ADR_W = 4, SETTLE = 4, CNT_W = 8;
  logic             clock = 0, reset = 1;
  logic [11:0]      adr_in = '0;
  logic             mux_en_in = 0, fault_clr = 0;
  logic [11:0]      adr_out, s_adr;
  logic             mux_en_out, fault, s_en, s_fault;
  logic [2:0]       conflict_mask, s_mask;
  logic [CNT_W-1:0] conflict_cnt;
  logic [1:0]       s_cnt;
  int checks = 0, passes = 0;
  bit started = 0;

  mux_guard #(.NCH(NCH), .ADR_W(ADR_W), .SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .adr_in(adr_in), .mux_en_in(mux_en_in), .fault_clr(fault_clr),
    .adr_out(adr_out), .mux_en_out(mux_en_out), .conflict_mask(conflict_mask), .fault(fault),
    .conflict_cnt(conflict_cnt));
  mux_guard #(.NCH(NCH), .ADR_W(ADR_W), .SETTLE(SETTLE), .CNT_W(2)) dut_s (
    .clock(clock), .reset(reset), .adr_in(adr_in), .mux_en_in(mux_en_in), .fault_clr(fault_clr),
    .adr_out(s_adr), .mux_en_out(s_en), .conflict_mask(s_mask), .fault(s_fault),
    .conflict_cnt(s_cnt));

  initial forever #5 clock = ~clock;

  function automatic logic [11:0] pk(int a0, int a1, int a2);
    return {4'(a2), 4'(a1), 4'(a0)};
  endfunction
  function automatic logic [2:0] mask_of(logic [11:0] a);
    logic [2:0] m = '0;
    for (int i = 0; i < NCH; i++)
      for (int j = 0; j < NCH; j++)
        if (i != j && a[i*4 +: 4] == a[j*4 +: 4]) m[i] = 1'b1;
    return m;
  endfunction
  function automatic int exp_cnt(int c, int w);
`ifdef MUX_GUARD_CNT_EN
    return (c > (1 << w) - 1) ? (1 << w) - 1 : c;
`else
    return 0 * c * w;
`endif
  endfunction
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Reference model: enabled once SETTLE+1 consecutive clean requests have been seen outside a fault.
  logic [11:0] m_adr = '0;
  logic [2:0]  m_mask = '0;
  bit          m_fault = 0, m_en = 0;
  int          m_run = 0, m_cnt = 0;
  always @(posedge clock) begin : model
    logic [2:0] nm;
    bit conf, good;
    nm = mask_of(m_adr);
    conf = |nm;
    if (reset) begin
      m_adr = '0; m_mask = '0; m_fault = 0; m_en = 0; m_run = 0; m_cnt = 0;
    end else begin
      good = mux_en_in && (adr_in == m_adr) && !conf;
      if (m_fault) begin
        if (fault_clr) m_fault = 0;
        m_run = 0;
      end else if (mux_en_in && conf) begin
        m_fault = 1; m_run = 0; m_cnt++;
      end else m_run = good ? m_run + 1 : 0;
      m_en = !m_fault && m_run >= SETTLE + 1;
      if (!m_en) m_adr = adr_in;
      m_mask = nm;
    end
  end

  always @(negedge clock) if (started) begin
    chk("adr_out", 32'(adr_out), 32'(m_adr));
    chk("mux_en_out", 32'(mux_en_out), 32'(m_en));
    chk("conflict_mask", 32'(conflict_mask), 32'(m_mask));
    chk("fault", 32'(fault), 32'(m_fault));
    chk("conflict_cnt", 32'(conflict_cnt), 32'(exp_cnt(m_cnt, CNT_W)));
    chk("sat_cnt", 32'(s_cnt), 32'(exp_cnt(m_cnt, 2)));
  end

  task automatic step();
    @(negedge clock);
  endtask
  task automatic wait_en();
    int n = 0;
    while (!mux_en_out && n < 20) begin step(); n++; end
    chk("wait_en", 32'(mux_en_out), 32'd1);
  endtask

  initial begin
    step();
    started = 1;
    step();
    chk("rst_en", 32'(mux_en_out), 0);
    chk("rst_adr", 32'(adr_out), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_cnt", 32'(conflict_cnt), 0);
    // clean enable: addresses at edge 1, request from edge 2, enable after edge 6
    reset = 0; adr_in = pk(2, 5, 9); mux_en_in = 0;
    step();
    mux_en_in = 1;
    for (int e = 2; e <= 5; e++) begin step(); chk("clean_early", 32'(mux_en_out), 0); end
    step();
    chk("clean_en", 32'(mux_en_out), 1);
    chk("clean_adr", 32'(adr_out), 32'(pk(2, 5, 9)));
    chk("clean_mask", 32'(conflict_mask), 0);
    chk("clean_fault", 32'(fault), 0);
    mux_en_in = 0;
    step();
    chk("drop_en", 32'(mux_en_out), 0);
    // re-settle after an address change while enabled
    adr_in = pk(1, 2, 4); mux_en_in = 1;
    wait_en();
    step();
    chk("frozen_adr", 32'(adr_out), 32'(pk(1, 2, 4)));
    adr_in = pk(1, 6, 4);
    step();
    chk("change_drop", 32'(mux_en_out), 0);
    for (int e = 1; e <= SETTLE; e++) begin step(); chk("resettle_early", 32'(mux_en_out), 0); end
    step();
    chk("resettle_en", 32'(mux_en_out), 1);
    chk("resettle_adr", 32'(adr_out), 32'(pk(1, 6, 4)));
    // collision
    adr_in = pk(3, 7, 3); mux_en_in = 0;
    step();
    mux_en_in = 1;
    step();
    chk("coll_fault", 32'(fault), 1);
    chk("coll_mask", 32'(conflict_mask), 32'b101);
    chk("coll_cnt", 32'(conflict_cnt), 32'(exp_cnt(1, CNT_W)));
    for (int e = 0; e < 3; e++) begin step(); chk("coll_noen", 32'(mux_en_out), 0); end
    // fault persistence under repeated clears
    reset = 1;
    step();
    reset = 0; adr_in = pk(0, 0, 1); mux_en_in = 1;
    step();
    chk("pers_fault0", 32'(fault), 1);
    for (int p = 0; p < 3; p++) begin
      fault_clr = 1; step(); chk("pers_clr", 32'(fault), 0);
      fault_clr = 0; step(); chk("pers_refault", 32'(fault), 1);
    end
    chk("pers_cnt", 32'(conflict_cnt), 32'(exp_cnt(4, CNT_W)));
    for (int p = 0; p < 2; p++) begin
      fault_clr = 1; step();
      fault_clr = 0; step();
    end
    chk("sat_cnt3", 32'(s_cnt), 32'(exp_cnt(6, 2)));
    chk("pers_cnt6", 32'(conflict_cnt), 32'(exp_cnt(6, CNT_W)));
    // reset while enabled
    fault_clr = 1; adr_in = pk(4, 8, 12); mux_en_in = 0;
    step();
    fault_clr = 0; mux_en_in = 1;
    wait_en();
    reset = 1;
    step();
    chk("rst_en_mid", 32'(mux_en_out), 0);
    chk("rst_adr_mid", 32'(adr_out), 0);
    chk("rst_cnt_mid", 32'(conflict_cnt), 0);
    reset = 0; mux_en_in = 0;
    step();
    mux_en_in = 1;
    for (int e = 2; e <= 5; e++) begin step(); chk("rerun_early", 32'(mux_en_out), 0); end
    step();
    chk("rerun_en", 32'(mux_en_out), 1);
    step();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
